ay_dac: RTL and testbench

- Output stage placed directly downstream of the AY-3-891x tone/noise mixer.
- Per channel, takes the mixed tone/noise bit (aout[2:0]) together with the R8–R10 amplitude fields and the envelope level.
- Scales each channel through a fixed logarithmic volume table, then sums the three channels into a 10-bit PCM value.
- Drives a first-order sigma-delta 1-bit output for an FPGA pin/RC filter, plus a decimated PCM sample with a valid tick.

---
 rtl/ay_pkg.sv | 20 ++
 rtl/ay_sigma_delta.sv | 23 ++
 rtl/ay_dac.sv | 91 +++++++++
 tb/tb_ay_dac.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ay_pkg.sv
// Shared constants for the AY-3-891x output stage: log volume table and field widths.
package ay_pkg;
  localparam int NUM_CH      = 3;
  localparam int PCM_W       = 10;
  localparam int VOL_W       = 8;
  localparam int LVL_W       = 4;
  localparam int AMP_W       = 5;
  localparam int AMP_ENV_BIT = 4;

  localparam logic [VOL_W-1:0] VOL_TABLE [16] = '{
    8'd0,  8'd2,  8'd3,  8'd4,  8'd6,   8'd8,   8'd11,  8'd16,
    8'd23, 8'd32, 8'd45, 8'd64, 8'd90,  8'd128, 8'd180, 8'd255
  };

  // Envelope-mode channels follow the envelope generator; others use their fixed level.
  function automatic logic [LVL_W-1:0] eff_level(input logic [AMP_W-1:0] amp,
                                                 input logic [LVL_W-1:0] env);
    return amp[AMP_ENV_BIT] ? env : amp[LVL_W-1:0];
  endfunction
endpackage

// File: rtl/ay_sigma_delta.sv
// First-order sigma-delta modulator: the carry out of a wrapping accumulator is the bitstream.
module ay_sigma_delta #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic         dout
);
  logic [W-1:0] acc;
  logic [W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, din};

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc  <= '0;
      dout <= 1'b0;
    end else begin
      acc  <= sum[W-1:0];
      dout <= sum[W];
    end
endmodule

// File: rtl/ay_dac.sv
// AY mixer output stage: 3-stage level/volume/sum pipeline, sigma-delta pin and decimated PCM.
module ay_dac
  import ay_pkg::*;
#(
  parameter int DECIM = 567
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ch_in,
  input  logic [4:0]       amp_a,
  input  logic [4:0]       amp_b,
  input  logic [4:0]       amp_c,
  input  logic [3:0]       env_level,
  input  logic             mute,
  output logic             dac_out,
  output logic [PCM_W-1:0] pcm,
  output logic [PCM_W-1:0] pcm_sample,
  output logic             pcm_tick
);
  localparam int CNT_W = (DECIM > 2) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [NUM_CH-1:0][AMP_W-1:0] amp;
  logic [NUM_CH-1:0][VOL_W-1:0] vol_s2;
  logic [NUM_CH-1:0]            ch_s1;
  logic                         mute_s1;
  logic [PCM_W-1:0]             mix;
  logic [CNT_W-1:0]             cnt;

  assign amp = {amp_c, amp_b, amp_a};

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ch_s1   <= '0;
      mute_s1 <= 1'b0;
    end else begin
      ch_s1   <= ch_in;
      mute_s1 <= mute;
    end

  // Per-channel S1 level register and S2 volume lookup.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [LVL_W-1:0] lvl;
    logic [VOL_W-1:0] vol;

    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        lvl <= '0;
        vol <= '0;
      end else begin
        lvl <= eff_level(amp[i], env_level);
        vol <= (ch_s1[i] && !mute_s1) ? VOL_TABLE[lvl] : '0;
      end

    assign vol_s2[i] = vol;
  end

  // 3 x 255 = 765 fits in PCM_W bits, so the sum never wraps.
  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_CH; i++)
      mix = mix + PCM_W'(vol_s2[i]);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) pcm <= '0;
    else        pcm <= mix;

  ay_sigma_delta #(.W(PCM_W)) u_sd (
    .clk   (clk),
    .reset (reset),
    .din   (pcm),
    .dout  (dac_out)
  );

  // Tick and sample share the edge on which the counter sits at its last value.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt        <= '0;
      pcm_tick   <= 1'b0;
      pcm_sample <= '0;
    end else begin
      pcm_tick <= (cnt == CNT_LAST);
      if (cnt == CNT_LAST) begin
        cnt        <= '0;
        pcm_sample <= pcm;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_ay_dac.sv
// Randomized scoreboard bench for ay_dac against a table-lookup reference model.
module tb_ay_dac;
  localparam int DECIM = 37;

  typedef struct {
    logic [2:0] ch;
    logic [4:0] a, b, c;
    logic [3:0] env;
    logic       mute;
  } in_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ch_in = '0;
  logic [4:0] amp_a = '0, amp_b = '0, amp_c = '0;
  logic [3:0] env_level = '0;
  logic       mute = 1'b0;
  logic       dac_out, pcm_tick;
  logic [9:0] pcm, pcm_sample;

  int vol_tab [16] = '{0, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 180, 255};
  int exp_q [$];
  int passed = 0, total = 0;
  int ones = 0;
  int edges;

  ay_dac #(.DECIM(DECIM)) dut (
    .clk(clk), .reset(reset), .ch_in(ch_in), .amp_a(amp_a), .amp_b(amp_b),
    .amp_c(amp_c), .env_level(env_level), .mute(mute), .dac_out(dac_out),
    .pcm(pcm), .pcm_sample(pcm_sample), .pcm_tick(pcm_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) edges <= 0;
    else        edges <= edges + 1;

  function automatic int chan_vol(input logic on, input logic [4:0] amp, input logic [3:0] env);
    int lvl;
    lvl = amp[4] ? int'(env) : int'(amp[3:0]);
    return on ? vol_tab[lvl] : 0;
  endfunction

  function automatic int model_pcm(input in_t s);
    if (s.mute) return 0;
    return chan_vol(s.ch[0], s.a, s.env) + chan_vol(s.ch[1], s.b, s.env) + chan_vol(s.ch[2], s.c, s.env);
  endfunction

  function automatic in_t mk(input logic [2:0] ch, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [3:0] env, input logic m);
    in_t s;
    s.ch = ch; s.a = a; s.b = b; s.c = c; s.env = env; s.mute = m;
    return s;
  endfunction

  function automatic in_t rnd_in();
    return mk(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom),
              ($urandom_range(0, 9) == 0));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic apply(input in_t s);
    ch_in = s.ch; amp_a = s.a; amp_b = s.b; amp_c = s.c; env_level = s.env; mute = s.mute;
  endtask

  task automatic step(input in_t s);
    @(posedge clk); #1;
    apply(s);
    exp_q.push_back(model_pcm(s));
  endtask

  // Hold reset for n_low clocks with random inputs, then release with rel applied.
  task automatic do_reset(input int n_low, input in_t rel);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q = {0, 0, 0};
    apply(rnd_in());
    #1;
    check("rst_pcm", int'(pcm), 0);
    check("rst_sample", int'(pcm_sample), 0);
    check("rst_tick", int'(pcm_tick), 0);
    check("rst_dac", int'(dac_out), 0);
    repeat (n_low - 1) begin
      @(posedge clk); #1;
      apply(rnd_in());
    end
    @(posedge clk); #1;
    reset = 1'b1;
    apply(rel);
    exp_q.push_back(model_pcm(rel));
  endtask

  // Call right after do_reset released with s: counts dac_out ones over 1024 clks of constant pcm.
  task automatic measure(input in_t s);
    repeat (3) step(s);
    step(s);
    ones = 0;
    repeat (1024) step(s);
    check("ones_1024", ones, model_pcm(s));
  endtask

  // Monitor: pops expected pcm, tracks tick cadence and the held sample.
  initial begin
    int cur, prev, exp_sample;
    bit tick_exp;
    prev = 0; exp_sample = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("hold_pcm", int'(pcm), 0);
        check("hold_sample", int'(pcm_sample), 0);
        check("hold_tick", int'(pcm_tick), 0);
        check("hold_dac", int'(dac_out), 0);
        prev = 0; exp_sample = 0;
      end else begin
        ones += int'(dac_out);
        cur = prev;
        if (exp_q.size() > 3) begin
          cur = exp_q.pop_front();
          check("pcm", int'(pcm), cur);
        end
        tick_exp = (edges > 0) && (edges % DECIM == 0);
        check("pcm_tick", int'(pcm_tick), int'(tick_exp));
        if (tick_exp) exp_sample = prev;
        check("pcm_sample", int'(pcm_sample), exp_sample);
        prev = cur;
      end
    end
  end

  initial begin
    in_t s;
    #2 reset = 1'b0;

    s = mk(3'b001, 5'h0F, 5'h00, 5'h00, 4'd0, 1'b0);
    do_reset(5, s);
    measure(s);

    s = mk(3'b111, 5'h0F, 5'h0F, 5'h0F, 4'd0, 1'b0);
    do_reset(1, s);
    measure(s);
    repeat (6) step(mk(3'b000, 5'h0F, 5'h0F, 5'h0F, 4'd0, 1'b0));
    repeat (20) begin
      step(mk(3'b000, 5'h0F, 5'h0F, 5'h0F, 4'd0, 1'b0));
      check("dac_idle", int'(dac_out), 0);
    end

    repeat (5) step(mk(3'b010, 5'h00, 5'h10, 5'h00, 4'd13, 1'b0));
    repeat (5) step(mk(3'b010, 5'h00, 5'h10, 5'h00, 4'd0, 1'b0));

    for (int l = 0; l < 16; l++) begin
      step(mk(3'b001, 5'(l), 5'h00, 5'h00, 4'd0, 1'b0));
      step(mk(3'b001, 5'(l), 5'h00, 5'h00, 4'd0, 1'b0));
    end
    repeat (4) step(mk(3'b001, 5'h0C, 5'h00, 5'h00, 4'd0, 1'b0));
    repeat (5) step(mk(3'b001, 5'h0C, 5'h00, 5'h00, 4'd0, 1'b1));
    repeat (5) step(mk(3'b001, 5'h0C, 5'h00, 5'h00, 4'd0, 1'b0));

    repeat (300) step(rnd_in());

    s = mk(3'b111, 5'h0F, 5'h0F, 5'h0F, 4'd0, 1'b0);
    repeat (10) step(s);
    do_reset(1, s);
    measure(s);

    repeat (300) step(rnd_in());
    repeat (4) step(mk(3'b000, 5'h00, 5'h00, 5'h00, 4'd0, 1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
